// File: rtl/alu_seq_legv8.sv
// Sequential LEGv8 ALU. The logic, add and shift ops finish in one cycle; unsigned
// MUL and UDIV iterate one bit per cycle. Valid/ready handshake on both sides.
module alu_seq_legv8 #(
  parameter int unsigned N = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         C0,
  input  logic [4:0]   FS,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] F,
  output logic [N-1:0] R,
  output logic [3:0]   status
);
  localparam int unsigned SHW = $clog2(N);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpXor = 3'b011;
  localparam logic [2:0] OpLsl = 3'b100;
  localparam logic [2:0] OpLsr = 3'b101;

  logic [1:0]     state_q, state_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic           is_div_q, is_div_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic [N-1:0]   opb_q, opb_d;
  logic [N-1:0]   f_q, f_d;
  logic [N-1:0]   r_q, r_d;
  logic [3:0]     status_q, status_d;

  logic [N-1:0]   a_s, b_s;
  logic [N:0]     add_sum;
  logic [N-1:0]   sc_f;
  logic           sc_c, sc_v;
  logic [SHW-1:0] shamt;
  logic [N:0]     mul_sum;
  logic [N:0]     div_shift, div_diff;
  logic           div_ok;
  logic [N-1:0]   it_hi, it_lo;

  assign a_s     = FS[0] ? ~A : A;
  assign b_s     = FS[1] ? ~B : B;
  assign shamt   = B[SHW-1:0];
  assign add_sum = {1'b0, a_s} + {1'b0, b_s} + {{N{1'b0}}, C0};

  always_comb begin
    sc_f = '0;
    sc_c = 1'b0;
    sc_v = 1'b0;
    case (FS[4:2])
      OpAnd: sc_f = a_s & b_s;
      OpOr:  sc_f = a_s | b_s;
      OpAdd: begin
        sc_f = add_sum[N-1:0];
        sc_c = add_sum[N];
        sc_v = ~(a_s[N-1] ^ b_s[N-1]) & (add_sum[N-1] ^ a_s[N-1]);
      end
      OpXor: sc_f = a_s ^ b_s;
      OpLsl: sc_f = A << shamt;
      OpLsr: sc_f = A >> shamt;
      default: sc_f = '0;
    endcase
  end

  // hi/lo hold {product high, multiplier} for MUL and {remainder, dividend/quotient} for UDIV.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(N+1){1'b0}});
    div_shift = {hi_q, lo_q[N-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ok    = ~div_diff[N];
    if (is_div_q) begin
      it_hi = div_ok ? div_diff[N-1:0] : div_shift[N-1:0];
      it_lo = {lo_q[N-2:0], div_ok};
    end else begin
      it_hi = mul_sum[N:1];
      it_lo = {mul_sum[0], lo_q[N-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    f_d      = f_q;
    r_d      = r_q;
    status_d = status_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (FS[4:3] == 2'b11) begin
            state_d  = StBusy;
            cnt_d    = SHW'(N - 1);
            is_div_d = FS[2];
            hi_d     = '0;
            lo_d     = a_s;
            opb_d    = b_s;
          end else begin
            state_d  = StDone;
            f_d      = sc_f;
            r_d      = '0;
            status_d = {sc_v, sc_c, sc_f[N-1], (sc_f == '0)};
          end
        end
      end
      StBusy: begin
        hi_d  = it_hi;
        lo_d  = it_lo;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          state_d = StDone;
          f_d     = it_lo;
          r_d     = it_hi;
          if (is_div_q) begin
            status_d = {(opb_q == '0), 1'b0, it_lo[N-1], (it_lo == '0)};
          end else begin
            status_d = {1'b0, (it_hi != '0), it_lo[N-1], (it_lo == '0)};
          end
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      f_q      <= '0;
      r_q      <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      f_q      <= f_d;
      r_q      <= r_d;
      status_q <= status_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign F         = f_q;
  assign R         = r_q;
  assign status    = status_q;
endmodule

// File: tb/tb_alu_seq_legv8.sv
// Bench for alu_seq_legv8: a 64-bit and a 16-bit instance checked against a wide-arithmetic
// reference model, with literal expectations pinning the model on the key vectors.
module tb_alu_seq_legv8;
  logic clk;
  logic rst;

  logic        iv   [2];
  logic        ordy [2];
  logic        c0   [2];
  logic [63:0] a    [2];
  logic [63:0] b    [2];
  logic [4:0]  fs   [2];

  logic        ir0, ov0, ir1, ov1;
  logic [63:0] f0, r0;
  logic [15:0] f1, r1;
  logic [3:0]  st0, st1;

  logic [63:0] ef [2];
  logic [63:0] er [2];
  logic [3:0]  es [2];
  bit          pend [2];

  int tests = 0;
  int fails = 0;

  alu_seq_legv8 #(.N(64)) u64 (
    .clock(clk), .reset(rst), .in_valid(iv[0]), .in_ready(ir0), .A(a[0]), .B(b[0]),
    .C0(c0[0]), .FS(fs[0]), .out_valid(ov0), .out_ready(ordy[0]), .F(f0), .R(r0),
    .status(st0)
  );

  alu_seq_legv8 #(.N(16)) u16 (
    .clock(clk), .reset(rst), .in_valid(iv[1]), .in_ready(ir1), .A(a[1][15:0]),
    .B(b[1][15:0]), .C0(c0[1]), .FS(fs[1]), .out_valid(ov1), .out_ready(ordy[1]), .F(f1),
    .R(r1), .status(st1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic get_ov(input int d);
    return (d == 0) ? ov0 : ov1;
  endfunction
  function automatic logic get_ir(input int d);
    return (d == 0) ? ir0 : ir1;
  endfunction
  function automatic logic [63:0] get_f(input int d);
    return (d == 0) ? f0 : {48'd0, f1};
  endfunction
  function automatic logic [63:0] get_r(input int d);
    return (d == 0) ? r0 : {48'd0, r1};
  endfunction
  function automatic logic [3:0] get_st(input int d);
    return (d == 0) ? st0 : st1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: n-bit ALU semantics evaluated with plain 128-bit arithmetic.
  function automatic void model(input int n, input logic [63:0] av, input logic [63:0] bv,
                                input logic cv, input logic [4:0] f, output logic [63:0] mf,
                                output logic [63:0] mr, output logic [3:0] ms);
    logic [127:0] m, as, bs, ra, res, rem, full;
    int sh;
    bit v, c;
    m   = (128'd1 << n) - 128'd1;
    as  = {64'd0, (f[0] ? ~av : av)} & m;
    bs  = {64'd0, (f[1] ? ~bv : bv)} & m;
    ra  = {64'd0, av} & m;
    sh  = int'(bv % 64'(n));
    v   = 0;
    c   = 0;
    rem = '0;
    res = '0;
    case (f[4:2])
      3'd0: res = as & bs;
      3'd1: res = as | bs;
      3'd2: begin
        full = as + bs + {127'd0, cv};
        c    = (full >> n) != 0;
        res  = full & m;
        v    = (as[n-1] == bs[n-1]) && (res[n-1] != as[n-1]);
      end
      3'd3: res = as ^ bs;
      3'd4: res = (ra << sh) & m;
      3'd5: res = ra >> sh;
      3'd6: begin
        full = as * bs;
        res  = full & m;
        rem  = full >> n;
        c    = rem != 0;
      end
      default: begin
        if (bs == 0) begin
          res = m;
          rem = as;
          v   = 1;
        end else begin
          res = as / bs;
          rem = as % bs;
        end
      end
    endcase
    mf = res[63:0];
    mr = rem[63:0];
    ms = {v, c, res[n-1], (res == 0)};
  endfunction

  // Every cycle a result is presented it must be one we expect, and match the model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (get_ov(d)) begin
          chk($sformatf("dut%0d_result_expected", d), {63'd0, pend[d]}, 64'd1);
          if (pend[d]) begin
            chk($sformatf("dut%0d_F", d), get_f(d), ef[d]);
            chk($sformatf("dut%0d_R", d), get_r(d), er[d]);
            chk($sformatf("dut%0d_status", d), {60'd0, get_st(d)}, {60'd0, es[d]});
            chk($sformatf("dut%0d_in_ready_in_done", d), {63'd0, get_ir(d)}, 64'd0);
          end
        end
      end
    end
  end

  task automatic issue(input int d, input logic [63:0] av, input logic [63:0] bv,
                       input logic cv, input logic [4:0] f, input int lat, input int hold,
                       input bit lit, input logic [63:0] lf, input logic [63:0] lr,
                       input logic [3:0] ls);
    logic [63:0] mf, mr;
    logic [3:0]  ms;
    int edges;
    model((d == 0) ? 64 : 16, av, bv, cv, f, mf, mr, ms);
    if (lit) begin
      chk($sformatf("model_F_fs%b", f), mf, lf);
      chk($sformatf("model_R_fs%b", f), mr, lr);
      chk($sformatf("model_status_fs%b", f), {60'd0, ms}, {60'd0, ls});
    end
    @(negedge clk);
    a[d]  = av;
    b[d]  = bv;
    c0[d] = cv;
    fs[d] = f;
    iv[d] = 1'b1;
    chk($sformatf("dut%0d_in_ready_idle", d), {63'd0, get_ir(d)}, 64'd1);
    @(posedge clk);
    #1;
    iv[d]   = 1'b0;
    ef[d]   = mf;
    er[d]   = mr;
    es[d]   = ms;
    pend[d] = 1'b1;
    edges   = 0;
    while (!get_ov(d) && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk($sformatf("dut%0d_latency_fs%b", d, f), 64'(edges), 64'(lat));
    // Hold in DONE; a pulsed in_valid with different operands must be ignored.
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == 2) begin
        iv[d] = 1'b1;
        a[d]  = ~av;
        fs[d] = 5'b01000;
      end else begin
        iv[d] = 1'b0;
      end
      chk($sformatf("dut%0d_held_valid", d), {63'd0, get_ov(d)}, 64'd1);
    end
    @(negedge clk);
    iv[d]   = 1'b0;
    ordy[d] = 1'b1;
    @(posedge clk);
    #1;
    ordy[d] = 1'b0;
    pend[d] = 1'b0;
    chk($sformatf("dut%0d_ov_after_take", d), {63'd0, get_ov(d)}, 64'd0);
    chk($sformatf("dut%0d_ir_after_take", d), {63'd0, get_ir(d)}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      iv[d]   = 1'b0;
      ordy[d] = 1'b0;
      c0[d]   = 1'b0;
      a[d]    = '0;
      b[d]    = '0;
      fs[d]   = '0;
      pend[d] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_ov%0d", d), {63'd0, get_ov(d)}, 64'd0);
      chk($sformatf("reset_ir%0d", d), {63'd0, get_ir(d)}, 64'd1);
      chk($sformatf("reset_F%0d", d), get_f(d), 64'd0);
      chk($sformatf("reset_R%0d", d), get_r(d), 64'd0);
      chk($sformatf("reset_status%0d", d), {60'd0, get_st(d)}, 64'd0);
    end

    // 64-bit single-cycle ops
    issue(0, 64'd5, 64'd3, 1'b0, 5'b01000, 0, 0, 1, 64'd8, 64'd0, 4'b0000);
    issue(0, 64'd5, 64'd5, 1'b1, 5'b01010, 0, 0, 1, 64'd0, 64'd0, 4'b0101);
    issue(0, 64'd3, 64'd5, 1'b1, 5'b01010, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 4'b0010);
    issue(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 5'b01000, 0, 0, 1,
          64'h8000_0000_0000_0000, 64'd0, 4'b1010);
    issue(0, 64'hF0F0, 64'hFF00, 1'b0, 5'b00000, 0, 0, 1, 64'hF000, 64'd0, 4'b0000);
    issue(0, 64'h1234_5678_9ABC_DEF0, 64'h00FF_00FF_00FF_00FF, 1'b0, 5'b00101, 0, 0, 0,
          64'd0, 64'd0, 4'd0);
    issue(0, 64'hAAAA_5555_AAAA_5555, 64'hFFFF_0000_FFFF_0000, 1'b0, 5'b01100, 0, 0, 0,
          64'd0, 64'd0, 4'd0);
    issue(0, 64'd1, 64'h7F, 1'b0, 5'b10000, 0, 0, 1, 64'h8000_0000_0000_0000, 64'd0, 4'b0010);
    issue(0, 64'h8000_0000_0000_0000, 64'd4, 1'b0, 5'b10100, 0, 0, 0, 64'd0, 64'd0, 4'd0);

    // 16-bit iterative ops
    issue(1, 64'd300, 64'd300, 1'b0, 5'b11000, 16, 5, 1, 64'h5F90, 64'h0001, 4'b0100);
    issue(1, 64'd100, 64'd7, 1'b0, 5'b11100, 16, 0, 1, 64'd14, 64'd2, 4'b0000);
    issue(1, 64'd100, 64'd0, 1'b0, 5'b11100, 16, 0, 1, 64'hFFFF, 64'd100, 4'b1010);
    issue(1, 64'hFFFF, 64'hFFFF, 1'b0, 5'b11000, 16, 0, 1, 64'h0001, 64'hFFFE, 4'b0100);
    issue(1, 64'hFFFF, 64'h0010, 1'b0, 5'b11100, 16, 0, 0, 64'd0, 64'd0, 4'd0);
    issue(1, 64'hFFFE, 64'hFFF0, 1'b0, 5'b11011, 16, 0, 0, 64'd0, 64'd0, 4'd0);
    issue(1, 64'hFFFF, 64'd1, 1'b0, 5'b01000, 0, 0, 1, 64'd0, 64'd0, 4'b0101);
    issue(1, 64'h8000, 64'h1F, 1'b0, 5'b10100, 0, 0, 1, 64'd1, 64'd0, 4'b0000);

    // Reset in the middle of a multiply: no result may ever appear for it.
    @(negedge clk);
    a[1]  = 64'd300;
    b[1]  = 64'd300;
    fs[1] = 5'b11000;
    iv[1] = 1'b1;
    @(posedge clk);
    #1;
    iv[1] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midreset_ov", {63'd0, ov1}, 64'd0);
    chk("midreset_ir", {63'd0, ir1}, 64'd1);
    chk("midreset_F", {48'd0, f1}, 64'd0);
    chk("midreset_R", {48'd0, r1}, 64'd0);
    chk("midreset_status", {60'd0, st1}, 64'd0);
    chk("midreset_F64", f0, 64'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("midreset_no_stale", {63'd0, ov1}, 64'd0);
    issue(1, 64'd2, 64'd2, 1'b0, 5'b01000, 0, 0, 1, 64'd4, 64'd0, 4'b0000);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_seq_legv8.md
Name: alu_seq_legv8

Overview:
- Parametrised, sequential successor to the 64-bit combinational LEGv8 ALU.
- Keeps the same FS-coded single-cycle ops (AND/OR/ADD/XOR/LSL/LSR with A/B invert).
- Adds iterative unsigned multiply and unsigned divide, with registered results and a valid/ready handshake on input and output.
- Sits between the register-read stage and writeback; the pipeline stalls on in_ready/out_valid.

Parameters:
- N, 64, datapath width; power of two, 8 <= N <= 64.
- SHW, $clog2(N), shift-amount width; localparam, not overridable.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and FS valid.
- in_ready  output  1  block can accept an operation.
- A  input  N  operand A.
- B  input  N  operand B; B[SHW-1:0] is the shift amount.
- C0  input  1  adder carry-in.
- FS  input  5  function select. FS[0]=invert A, FS[1]=invert B, FS[4:2]=op.
- out_valid  output  1  F/R/status valid.
- out_ready  input  1  consumer takes the result.
- F  output  N  primary result.
- R  output  N  secondary result: MUL high half, UDIV remainder, else 0.
- status  output  4  {V,C,N,Z}.

Behaviour:
- Op encoding FS[4:2]: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 LSL, 101 LSR, 110 MUL, 111 UDIV.
- Operand conditioning: As = FS[0] ? ~A : A; Bs = FS[1] ? ~B : B.
  - AND/OR/XOR/ADD/MUL/UDIV use As and Bs.
  - LSL/LSR shift the raw A by B[SHW-1:0], zero fill.
- Operand capture: A, B, FS and C0 are registered on the accepting edge (in_valid & in_ready). Inputs are ignored at all other times.
- FSM states: IDLE, BUSY, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
  - IDLE -> DONE on accept of a single-cycle op (000-101). Result is registered at the accepting edge, so out_valid is high in the next cycle.
  - IDLE -> BUSY on accept of MUL/UDIV. Iteration counter loads N-1.
  - BUSY: one iteration per cycle, exactly N iterations. -> DONE on the edge that completes iteration N. out_valid rises N edges after the accepting edge.
  - DONE: F/R/status held stable. -> IDLE on out_ready. No accept in the same cycle (one bubble).
- MUL: shift-add, unsigned As*Bs as a 2N-bit product. F = low N bits, R = high N bits.
- UDIV: restoring division, unsigned. F = As/Bs, R = As%Bs.
- Divide by zero (Bs==0): still takes N cycles. F = all ones, R = As, V=1.
- Status flags (computed from the final F):
  - N = F[N-1]; Z = (F==0).
  - ADD: C = adder carry-out of As+Bs+C0; V = ~(As[N-1]^Bs[N-1]) & (F[N-1]^As[N-1]).
  - MUL: C = (R!=0), V=0.
  - UDIV: C=0; V = divide-by-zero.
  - Logic and shift ops: C=0, V=0.
- Reset, at any point including mid-BUSY:
  - Next state IDLE; in-flight op discarded with no result.
  - out_valid=0, in_ready=1, F=0, R=0, status=0 after the reset edge.
  - Counter and internal accumulators are cleared.
- out_ready while not DONE: ignored. in_valid while not IDLE: ignored, not queued.
- Wrap-around: ADD wraps modulo 2^N with the carry in C. Shift amounts >= N are impossible by width (SHW bits).

Test Plan:
- N=64, ADD: A=5, B=3, FS=01000, C0=0 -> out_valid in the cycle after accept; F=8, R=0, status=0000.
- N=64, SUB: A=5, B=5, FS=01010, C0=1 -> F=0, status {V,C,N,Z}=0101. Then A=3, B=5 -> F=0xFFFF_FFFF_FFFF_FFFE, status=0010.
- N=16, MUL: A=300, B=300, FS=11000 -> out_valid exactly 16 edges after accept; F=0x5F90, R=0x0001, status=0100.
- N=16, UDIV: A=100, B=7, FS=11100 -> F=14, R=2, status=0000. Then B=0 -> F=0xFFFF, R=100, status=1010.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> F/R/status stable, in_ready=0, a pulsed in_valid is ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-MUL: assert reset 5 cycles after accept -> next cycle out_valid=0, in_ready=1, F=0. No stale result appears afterwards; a new ADD completes correctly.
